// File: rtl/ece429_regfile_mp_if.sv
// Register-file access bundle: packed read ports, one write port, ready flag and,
// with REGFILE_SCOREBOARD_EN defined, the hazard scoreboard set/pending signals.
interface ece429_regfile_mp_if #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic                    ready;
`ifdef REGFILE_SCOREBOARD_EN
    logic                    sb_set_en;
    logic [AW-1:0]           sb_set_addr;
    logic [NUM_RD-1:0]       rd_pending;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
                    input  rd_data, ready, rd_pending);
    modport slave  (input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
                    output rd_data, ready, rd_pending);
`else
    modport master (output rd_addr, wr_en, wr_addr, wr_data,
                    input  rd_data, ready);
    modport slave  (input  rd_addr, wr_en, wr_addr, wr_data,
                    output rd_data, ready);
`endif
endinterface

// File: rtl/ece429_regfile_mp.sv
// Multi-read-port MIPS register file: registered reads with write-first bypass, r0 = 0,
// post-reset init sequencer; optional hazard scoreboard under REGFILE_SCOREBOARD_EN.
module ece429_regfile_mp #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 32,
    parameter int               AW      = 5,
    parameter int               NUM_RD  = 2,
    parameter int               SP_IDX  = 29,
    parameter logic [WIDTH-1:0] SP_INIT = 32'h80120000,
    parameter int               RA_IDX  = 31
) (
    input logic                  clock,
    input logic                  reset_n,
    ece429_regfile_mp_if.slave   bus
);
    localparam logic [0:0]    ST_INIT = 1'b0;
    localparam logic [0:0]    ST_RUN  = 1'b1;
    localparam logic [AW-1:0] SP_A    = AW'(SP_IDX);
    localparam logic [AW-1:0] RA_A    = AW'(RA_IDX);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    logic [0:0]              state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic                    mem_we;
    logic [AW-1:0]           mem_waddr;
    logic [WIDTH-1:0]        mem_wdata;
    logic [NUM_RD*WIDTH-1:0] rd_data_q, rd_data_d;

    function automatic logic [WIDTH-1:0] init_value(input logic [AW-1:0] idx);
        if (idx == SP_A)                   return SP_INIT;
        else if (idx == RA_A || idx == '0) return '0;
        else                               return WIDTH'(idx);
    endfunction

    // The init sequencer owns the single array write port until RUN.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = init_value(idx_q);
            idx_d     = idx_q + AW'(1);
            if (idx_q == LAST_A) state_d = ST_RUN;
        end else begin
            mem_we = bus.wr_en && (bus.wr_addr != '0);
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (state_q == ST_RUN && bus.rd_addr[k*AW +: AW] != '0) begin
                if (bus.wr_en && bus.wr_addr == bus.rd_addr[k*AW +: AW])
                    rd_data_d[k*WIDTH +: WIDTH] = bus.wr_data;
                else
                    rd_data_d[k*WIDTH +: WIDTH] = mem_q[bus.rd_addr[k*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            idx_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Array contents are not reset; the init sequence rewrites every entry.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.ready   = (state_q == ST_RUN);
    assign bus.rd_data = rd_data_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0]  pend_q, pend_d, pend_clr;
    logic [NUM_RD-1:0] rd_pend_q, rd_pend_d;

    // Reads see the pending vector after this cycle's clear but before its set.
    always_comb begin
        pend_clr = pend_q;
        if (state_q == ST_RUN && bus.wr_en) pend_clr[bus.wr_addr] = 1'b0;
        pend_d = pend_clr;
        if (state_q == ST_RUN && bus.sb_set_en) pend_d[bus.sb_set_addr] = 1'b1;
        pend_d[0] = 1'b0;
        rd_pend_d = '0;
        for (int k = 0; k < NUM_RD; k++)
            rd_pend_d[k] = (state_q == ST_RUN) && pend_clr[bus.rd_addr[k*AW +: AW]];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= '0;
            rd_pend_q <= '0;
        end else begin
            pend_q    <= pend_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign bus.rd_pending = rd_pend_q;
`endif
endmodule
